// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-path types and constants for the dual-issue core.
package cpu_pkg;
    localparam int PC_W_DEF  = 12;
    localparam int BUNDLE_W  = 64;
    localparam int SLOT_W    = 32;
    localparam int SLOT1_LSB = 32;
    localparam int SLOT2_LSB = 0;

    typedef struct packed {
        logic [BUNDLE_W-1:0] bundle;
        logic [PC_W_DEF-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_fifo.sv
// fetch_queue_fifo: circular buffer of fetch entries with push, pop, flush and occupancy count.
module fetch_queue_fifo
    import cpu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t,
    parameter int  CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  T              i_push_data,
    input  logic          i_pop,
    output T              o_head,
    output logic [CW-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_push_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (i_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    // Empty queue presents an all-zero head rather than stale storage.
    assign o_head  = (r_count != '0) ? r_mem[r_rd] : '0;
    assign o_count = r_count;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner, ROM read issue and bundle queue with redirect flush.
// Define FETCH_QUEUE_PERF_EN to add saturating flush/stall performance counters.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_en,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [BUNDLE_W-1:0] imem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BUNDLE_W-1:0] out_bundle,
    output logic [PC_W-1:0]     out_pc,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [15:0]         perf_flush_cnt,
    output logic [15:0]         perf_stall_cnt
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [BUNDLE_W-1:0] bundle;
        logic [PC_W-1:0]     pc;
    } entry_t;

    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] r_inflight_pc;
    logic            r_inflight;
    logic            r_kill;
    logic [CW-1:0]   w_count;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    entry_t          w_head;
    entry_t          w_push_data;

    // Reserve a slot for the outstanding read so a response can always be pushed.
    assign w_issue     = rst_n && !redirect_valid && ((w_count + CW'(r_inflight)) < CW'(DEPTH));
    assign w_push      = r_inflight && !r_kill && !redirect_valid;
    assign w_pop       = out_valid && out_ready && !redirect_valid;
    assign w_push_data = '{bundle: imem_rdata, pc: r_inflight_pc};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_kill        <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_kill     <= redirect_valid && r_inflight;
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_issue) begin
                r_fetch_pc    <= r_fetch_pc + PC_W'(1);
                r_inflight_pc <= r_fetch_pc;
            end
        end
    end

    fetch_queue_fifo #(
        .DEPTH(DEPTH),
        .T    (entry_t),
        .CW   (CW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (redirect_valid),
        .i_push     (w_push),
        .i_push_data(w_push_data),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_count)
    );

    assign imem_en    = w_issue;
    assign imem_addr  = r_fetch_pc;
    assign out_valid  = (w_count != '0);
    assign out_bundle = w_head.bundle;
    assign out_pc     = w_head.pc;

`ifdef FETCH_QUEUE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_flush_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (redirect_valid && perf_flush_cnt != 16'hFFFF) perf_flush_cnt <= perf_flush_cnt + 16'd1;
            if (w_count == '0 && perf_stall_cnt != 16'hFFFF) perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: vector table, directed corner sequences and random traffic against a queue-based model.
module tb_fetch_queue;
    import cpu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, imem_en, out_valid, out_ready, redirect_valid;
    logic [11:0] imem_addr, out_pc, redirect_pc;
    logic [63:0] imem_rdata, out_bundle;
`ifdef FETCH_QUEUE_PERF_EN
    logic [15:0] perf_flush_cnt, perf_stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: fetch PC, the one outstanding read, and the queue of buffered PCs.
    logic [11:0] q[$];
    logic [11:0] m_pc      = '0;
    logic [11:0] m_pend_pc = '0;
    bit          m_pend    = 1'b0;

    typedef struct {
        bit          rstn, rdy, rv;
        logic [11:0] rpc;
        bit          en;
        logic [11:0] addr;
        bit          vld;
        logic [11:0] pc;
    } vec_t;

    vec_t vt[27] = '{
        '{0, 1, 0, 12'h000, 0, 12'h000, 0, 12'h000},
        '{1, 1, 0, 12'h000, 1, 12'h000, 0, 12'h000},
        '{1, 1, 0, 12'h000, 1, 12'h001, 0, 12'h000},
        '{1, 1, 0, 12'h000, 1, 12'h002, 1, 12'h000},
        '{1, 1, 0, 12'h000, 1, 12'h003, 1, 12'h001},
        '{1, 1, 0, 12'h000, 1, 12'h004, 1, 12'h002},
        '{0, 0, 0, 12'h000, 0, 12'h005, 1, 12'h003},
        '{0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000},
        '{1, 0, 0, 12'h000, 1, 12'h000, 0, 12'h000},
        '{1, 0, 0, 12'h000, 1, 12'h001, 0, 12'h000},
        '{1, 0, 0, 12'h000, 1, 12'h002, 1, 12'h000},
        '{1, 0, 0, 12'h000, 1, 12'h003, 1, 12'h000},
        '{1, 0, 0, 12'h000, 0, 12'h004, 1, 12'h000},
        '{1, 0, 0, 12'h000, 0, 12'h004, 1, 12'h000},
        '{1, 1, 0, 12'h000, 0, 12'h004, 1, 12'h000},
        '{1, 1, 0, 12'h000, 1, 12'h004, 1, 12'h001},
        '{1, 1, 0, 12'h000, 1, 12'h005, 1, 12'h002},
        '{1, 1, 1, 12'h100, 0, 12'h006, 1, 12'h003},
        '{1, 1, 0, 12'h000, 1, 12'h100, 0, 12'h000},
        '{1, 1, 0, 12'h000, 1, 12'h101, 0, 12'h000},
        '{1, 1, 0, 12'h000, 1, 12'h102, 1, 12'h100},
        '{1, 1, 1, 12'hFFE, 0, 12'h103, 1, 12'h101},
        '{1, 1, 0, 12'h000, 1, 12'hFFE, 0, 12'h000},
        '{1, 1, 0, 12'h000, 1, 12'hFFF, 0, 12'h000},
        '{1, 1, 0, 12'h000, 1, 12'h000, 1, 12'hFFE},
        '{1, 1, 0, 12'h000, 1, 12'h001, 1, 12'hFFF},
        '{1, 1, 0, 12'h000, 1, 12'h002, 1, 12'h000}
    };

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH   (DEPTH),
        .PC_W    (12),
        .RESET_PC(12'h000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_bundle    (out_bundle),
        .out_pc        (out_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_flush_cnt(perf_flush_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    function automatic logic [63:0] rom(input logic [11:0] a);
        return {32'(a) * 32'h9E3779B1, 20'hC0DE5, a};
    endfunction

    always @(posedge clk) if (imem_en) imem_rdata <= rom(imem_addr);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input bit rs, input bit rd, input bit rv, input logic [11:0] rp);
        bit          e_v;
        logic [11:0] e_pc;
        @(negedge clk);
        rst_n          = rs;
        out_ready      = rd;
        redirect_valid = rv;
        redirect_pc    = rp;
        #1;
        e_v  = q.size() > 0;
        e_pc = e_v ? q[0] : 12'h000;
        chk("model_en", imem_en, rs && !rv && (q.size() + int'(m_pend) < DEPTH));
        chk("model_addr", imem_addr, m_pc);
        chk("model_valid", out_valid, e_v);
        chk("model_pc", out_pc, e_pc);
        chk("model_bundle", out_bundle, e_v ? rom(e_pc) : 64'h0);
    endtask

    task automatic adv();
        bit issue;
        @(posedge clk);
        if (!rst_n || redirect_valid) begin
            q.delete();
            m_pc   = !rst_n ? 12'h000 : redirect_pc;
            m_pend = 1'b0;
        end else begin
            issue = (q.size() + int'(m_pend)) < DEPTH;
            if (out_ready && q.size() > 0) void'(q.pop_front());
            if (m_pend) q.push_back(m_pend_pc);
            m_pend = issue;
            if (issue) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 12'd1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_rdata = '0;
        @(posedge clk);

        foreach (vt[i]) begin
            set_in(vt[i].rstn, vt[i].rdy, vt[i].rv, vt[i].rpc);
            chk($sformatf("vec%0d_en", i), imem_en, vt[i].en);
            chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].addr);
            chk($sformatf("vec%0d_valid", i), out_valid, vt[i].vld);
            chk($sformatf("vec%0d_pc", i), out_pc, vt[i].pc);
            chk($sformatf("vec%0d_bundle", i), out_bundle, vt[i].vld ? rom(vt[i].pc) : 64'h0);
            adv();
        end

        // Fill the queue, then redirect with out_ready high: nothing pops, queue empties.
        repeat (4) begin set_in(1, 0, 0, 0); adv(); end
        set_in(1, 1, 1, 12'h200);
        chk("full_no_issue", imem_en, 0);
        chk("full_head_pc", out_pc, 12'h001);
        adv();
        set_in(1, 1, 0, 0);
        chk("flush_empty", out_valid, 0);
        chk("flush_addr", imem_addr, 12'h200);
        adv();
        set_in(1, 1, 0, 0); adv();
        set_in(1, 1, 0, 0);
        chk("after_flush_pc", out_pc, 12'h200);
        adv();

        for (int i = 0; i < 500; i++) begin
            set_in($urandom_range(0, 49) != 0, $urandom_range(0, 2) != 0,
                   $urandom_range(0, 11) == 0, 12'($urandom));
            adv();
        end

`ifdef FETCH_QUEUE_PERF_EN
        set_in(0, 0, 0, 0); adv();
        repeat (3) begin set_in(1, 0, 1, 12'h040); adv(); end
        set_in(1, 0, 0, 0);
        chk("perf_flush_3", perf_flush_cnt, 16'd3);
        adv();
        @(negedge clk); redirect_valid = 1'b1;
        repeat (32'h10000) @(posedge clk);
        @(negedge clk);
        chk("perf_stall_sat", perf_stall_cnt, 16'hFFFF);
        chk("perf_flush_sat", perf_flush_cnt, 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
